// File: rtl/rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rx_buffer_pkg
// Purpose  : Shared definitions for the receive buffer: capture FSM state
//            encodings, default FIFO geometry, FIFO entry layout and the
//            bit positions of the error flags inside the stored error field.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package rx_buffer_pkg;

  // Default FIFO geometry (DEPTH must equal 2**AW)
  localparam int c_DEPTH_DEFAULT = 8;
  localparam int c_AW_DEFAULT    = 3;

  // FIFO entry layout: {err[2:0], data[7:0]}
  localparam int c_DATA_W  = 8;
  localparam int c_ERR_W   = 3;
  localparam int c_ENTRY_W = c_DATA_W + c_ERR_W;

  // Bit positions inside the error field
  localparam int c_ERR_PERR_BIT = 0;
  localparam int c_ERR_FERR_BIT = 1;
  localparam int c_ERR_OVF_BIT  = 2;

  // Capture FSM encodings (2 bits)
  localparam logic [1:0] c_ST_IDLE     = 2'b00;
  localparam logic [1:0] c_ST_ACK      = 2'b01;
  localparam logic [1:0] c_ST_WAIT_LOW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = c_ST_IDLE,
    ST_ACK      = c_ST_ACK,
    ST_WAIT_LOW = c_ST_WAIT_LOW
  } state_t;

  // Assemble the stored error field from the individual engine flags
  function automatic logic [c_ERR_W-1:0] pack_err(input logic ovf,
                                                  input logic ferr,
                                                  input logic perr);
    logic [c_ERR_W-1:0] v;
    v                 = '0;
    v[c_ERR_OVF_BIT]  = ovf;
    v[c_ERR_FERR_BIT] = ferr;
    v[c_ERR_PERR_BIT] = perr;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_buffer_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO holding the received
//            entries. Head entry is presented combinationally on rd_data.
//            A push is accepted when not full, or when full and a pop happens
//            on the same edge (the pop frees the slot being written).
// Ports    : clk, rst (async, active-low)
//            wr_en/wr_data   - push request and entry
//            rd_en           - pop request (ignored when empty)
//            rd_data         - head entry
//            empty/full/count- occupancy status
//            wr_reject       - push request refused because the FIFO is full
// Revision : 1.0 - initial release
// ============================================================================
module rx_buffer_sync_fifo
  import rx_buffer_pkg::*;
#(
  parameter int WIDTH = c_ENTRY_W,
  parameter int DEPTH = c_DEPTH_DEFAULT,
  parameter int AW    = c_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             wr_reject
);

  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop     = rd_en && (r_count != '0);
  assign w_push    = wr_en && ((r_count != c_FULL) || w_pop);
  assign wr_reject = wr_en && !w_push;

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign empty   = (r_count == '0);
  assign full    = (r_count == c_FULL);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_buffer
// Purpose  : Receive buffer between a UART-style receive engine and a host.
//            A capture FSM takes one byte (plus error flags) per rxrdy
//            assertion, acknowledges the engine with a one-cycle clr pulse and
//            waits for rxrdy to drop before re-arming. Captured entries go
//            into a FWFT FIFO; bytes arriving while full are discarded and
//            flagged on the sticky drop output.
// Ports    : clk, rst (async, active-low)
//            rxrdy, rx_data, perr, ferr, ovf - engine side inputs
//            clr                             - engine acknowledge pulse
//            rd                              - host pop strobe
//            dout, dout_err                  - head byte and {ovf,ferr,perr}
//            empty, full, count              - FIFO status
//            drop, drop_clr                  - sticky discard flag and clear
// Revision : 1.0 - initial release
// ============================================================================
module rx_buffer
  import rx_buffer_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEFAULT,
  parameter int AW    = c_AW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxrdy,
  input  logic [c_DATA_W-1:0] rx_data,
  input  logic                perr,
  input  logic                ferr,
  input  logic                ovf,
  output logic                clr,
  input  logic                rd,
  output logic [c_DATA_W-1:0] dout,
  output logic [c_ERR_W-1:0]  dout_err,
  output logic                empty,
  output logic                full,
  output logic [AW:0]         count,
  output logic                drop,
  input  logic                drop_clr
);

  state_t               r_state;
  logic                 r_clr;
  logic                 r_drop;
  logic                 w_capture;
  logic                 w_wr_reject;
  logic [c_ENTRY_W-1:0] w_wr_entry;
  logic [c_ENTRY_W-1:0] w_rd_entry;

  // A capture happens only on the edge where IDLE sees rxrdy high
  assign w_capture  = (r_state == ST_IDLE) && rxrdy;
  assign w_wr_entry = {pack_err(ovf, ferr, perr), rx_data};

  rx_buffer_sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sync_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (w_capture),
    .wr_data   (w_wr_entry),
    .rd_en     (rd),
    .rd_data   (w_rd_entry),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .wr_reject (w_wr_reject)
  );

  // clr is a flop that is high exactly while the FSM sits in ACK, so the
  // engine sees a clean pulse with no path from rxrdy or rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_clr   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rxrdy) begin
            r_state <= ST_ACK;
            r_clr   <= 1'b1;
          end
        end
        ST_ACK: begin
          r_state <= ST_WAIT_LOW;
          r_clr   <= 1'b0;
        end
        ST_WAIT_LOW: begin
          if (!rxrdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_clr   <= 1'b0;
        end
      endcase

      // Setting the flag takes priority over clearing it
      if (w_capture && w_wr_reject) begin
        r_drop <= 1'b1;
      end else if (drop_clr) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign clr      = r_clr;
  assign drop     = r_drop;
  assign dout     = w_rd_entry[c_DATA_W-1:0];
  assign dout_err = w_rd_entry[c_ENTRY_W-1:c_DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_buffer
// Purpose  : Self-checking bench for rx_buffer: a directed vector table,
//            hand-written multi-cycle sequences and randomized traffic, all
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxrdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          perr = 1'b0;
  logic          ferr = 1'b0;
  logic          ovf = 1'b0;
  logic          rd = 1'b0;
  logic          drop_clr = 1'b0;
  logic          clr;
  logic [7:0]    dout;
  logic [2:0]    dout_err;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          drop;

  int n_checks = 0;
  int n_pass   = 0;

  rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxrdy    (rxrdy),
    .rx_data  (rx_data),
    .perr     (perr),
    .ferr     (ferr),
    .ovf      (ovf),
    .clr      (clr),
    .rd       (rd),
    .dout     (dout),
    .dout_err (dout_err),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .drop     (drop),
    .drop_clr (drop_clr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mq holds {ovf,ferr,perr,data}; m_busy means a byte was already taken for
  // the current rxrdy assertion (or the ack cycle is in progress).
  logic [10:0] mq[$];
  bit          m_drop;
  bit          m_clr;
  bit          m_busy;

  task automatic model_reset();
    mq.delete();
    m_drop = 1'b0;
    m_clr  = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, cap, was_full, dset;
    pop      = rd && (mq.size() > 0);
    cap      = rxrdy && !m_busy;
    was_full = (mq.size() == DEPTH);
    dset     = 1'b0;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (was_full && !pop) dset = 1'b1;
      else mq.push_back({ovf, ferr, perr, rx_data});
    end
    m_busy = cap ? 1'b1 : (m_clr ? 1'b1 : (m_busy && rxrdy));
    m_clr  = cap;
    m_drop = dset ? 1'b1 : (drop_clr ? 1'b0 : m_drop);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("m_clr", clr, m_clr);
    check("m_count", count, mq.size());
    check("m_empty", empty, mq.size() == 0);
    check("m_full", full, mq.size() == DEPTH);
    check("m_drop", drop, m_drop);
    if (mq.size() > 0) begin
      check("m_dout", dout, mq[0][7:0]);
      check("m_dout_err", dout_err, mq[0][10:8]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // One complete handshake; returns clr as seen right after the capture edge
  task automatic send(input logic [7:0] d, input logic [2:0] e, input logic rd_cap,
                      input logic dclr_cap, output logic cap_clr);
    rxrdy = 1'b1; rx_data = d; {ovf, ferr, perr} = e; rd = rd_cap; drop_clr = dclr_cap;
    step();
    cap_clr = clr;
    rxrdy = 1'b0; rd = 1'b0; drop_clr = 1'b0;
    step();
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rxrdy;
    logic [7:0] data;
    logic [2:0] err;
    logic       rd;
    logic       dclr;
    logic       exp_clr;
    int         exp_count;
    logic       exp_drop;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic rr, input logic [7:0] d, input logic [2:0] e,
                              input logic r, input logic dc, input logic ec, input int cnt,
                              input logic ed, input logic cd, input logic [7:0] xd,
                              input logic [2:0] xe);
    vec_t v;
    v.rxrdy = rr; v.data = d; v.err = e; v.rd = r; v.dclr = dc;
    v.exp_clr = ec; v.exp_count = cnt; v.exp_drop = ed;
    v.chk_dout = cd; v.exp_dout = xd; v.exp_err = xe;
    return v;
  endfunction

  logic       cclr;
  int         pct;
  logic [7:0] exp_b;

  initial begin
    //            rxrdy data  err   rd dclr clr cnt drop chk dout  err
    vt[0]  = mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000);
    vt[1]  = mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000);
    vt[2]  = mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000);
    vt[3]  = mk(1, 8'hA5, 3'b000, 0, 0, 1, 1, 0, 1, 8'hA5, 3'b000);
    vt[4]  = mk(1, 8'hA5, 3'b000, 0, 0, 0, 1, 0, 1, 8'hA5, 3'b000);
    vt[5]  = mk(1, 8'hA5, 3'b000, 0, 0, 0, 1, 0, 1, 8'hA5, 3'b000);
    vt[6]  = mk(0, 8'h00, 3'b000, 0, 0, 0, 1, 0, 1, 8'hA5, 3'b000);
    vt[7]  = mk(1, 8'h3C, 3'b011, 0, 0, 1, 2, 0, 1, 8'hA5, 3'b000);
    vt[8]  = mk(0, 8'h00, 3'b000, 0, 0, 0, 2, 0, 1, 8'hA5, 3'b000);
    vt[9]  = mk(0, 8'h00, 3'b000, 1, 0, 0, 1, 0, 1, 8'h3C, 3'b011);
    vt[10] = mk(1, 8'h5A, 3'b100, 0, 0, 1, 2, 0, 1, 8'h3C, 3'b011);
    vt[11] = mk(0, 8'h00, 3'b000, 1, 0, 0, 1, 0, 1, 8'h5A, 3'b100);
    vt[12] = mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000);
    vt[13] = mk(0, 8'h00, 3'b000, 1, 0, 0, 0, 0, 0, 8'h00, 3'b000);
    vt[14] = mk(0, 8'h00, 3'b000, 0, 1, 0, 0, 0, 0, 8'h00, 3'b000);

    // ---- reset state ----
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_clr", clr, 1'b0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_drop", drop, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // ---- table: pop on empty, single byte, error flags ----
    for (int i = 0; i < 15; i++) begin
      rxrdy = vt[i].rxrdy; rx_data = vt[i].data; {ovf, ferr, perr} = vt[i].err;
      rd = vt[i].rd; drop_clr = vt[i].dclr;
      step();
      check($sformatf("v%0d_clr", i), clr, vt[i].exp_clr);
      check($sformatf("v%0d_count", i), count, vt[i].exp_count);
      check($sformatf("v%0d_empty", i), empty, vt[i].exp_count == 0);
      check($sformatf("v%0d_drop", i), drop, vt[i].exp_drop);
      if (vt[i].chk_dout) begin
        check($sformatf("v%0d_dout", i), dout, vt[i].exp_dout);
        check($sformatf("v%0d_err", i), dout_err, vt[i].exp_err);
      end
    end
    rd = 1'b0; drop_clr = 1'b0;

    // ---- fill, overflow discard, drop priority, full write+pop ----
    for (int i = 0; i < 8; i++) send(8'(i), 3'b000, 1'b0, 1'b0, cclr);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 8);
    send(8'hFF, 3'b000, 1'b0, 1'b0, cclr);
    check("ovf_clr", cclr, 1'b1);
    check("ovf_drop", drop, 1'b1);
    check("ovf_count", count, 8);
    check("ovf_head", dout, 8'h00);
    send(8'hEE, 3'b000, 1'b0, 1'b1, cclr);
    check("drop_set_wins", drop, 1'b1);
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    check("drop_cleared", drop, 1'b0);
    send(8'h77, 3'b000, 1'b1, 1'b0, cclr);
    check("wrpop_drop", drop, 1'b0);
    check("wrpop_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 1) : 8'h77;
      check($sformatf("drain%0d", i), dout, exp_b);
      rd = 1'b1;
      step();
      rd = 1'b0;
    end
    check("drain_empty", empty, 1'b1);

    // ---- reset in WAIT_LOW with rxrdy held ----
    send(8'h11, 3'b000, 1'b0, 1'b0, cclr);
    rxrdy = 1'b1; rx_data = 8'h33; {ovf, ferr, perr} = 3'b000;
    step();
    step();
    step();
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_clr", clr, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_full", full, 1'b0);
    check("mid_rst_drop", drop, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("recap_clr", clr, 1'b1);
    check("recap_dout", dout, 8'h33);
    step();
    check("recap_clr_low", clr, 1'b0);
    step();
    check("recap_once", count, 1);
    rxrdy = 1'b0;
    step();
    step();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      pct      = (((c / 400) % 2) == 0) ? 15 : 70;
      rxrdy    = ($urandom_range(0, 99) < 60);
      rx_data  = 8'($urandom);
      {ovf, ferr, perr} = 3'($urandom);
      rd       = ($urandom_range(0, 99) < pct);
      drop_clr = ($urandom_range(0, 99) < 4);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
